// File: rtl/mem_burst_ctrl_if.sv
// Burst request, write/read data streams and memory-side handshake of mem_burst_ctrl.
// The controller connects through the slave modport; its environment uses master.
interface mem_burst_ctrl_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_wr_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [LEN_WIDTH-1:0]  req_len_i;
  logic                  wd_valid_i;
  logic                  wd_ready_o;
  logic [WIDTH-1:0]      wd_data_i;
  logic                  rd_valid_o;
  logic                  rd_ready_i;
  logic [WIDTH-1:0]      rd_data_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0]      mem_wdata_o;
  logic [WIDTH-1:0]      mem_rdata_i;
  logic                  mem_wr_rd_o;
  logic                  mem_valid_o;
  logic                  mem_ready_i;
  logic                  busy_o;
  logic                  done_o;

  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i, req_len_i,
    input  wd_valid_i, wd_data_i, rd_ready_i, mem_rdata_i, mem_ready_i,
    output req_ready_o, wd_ready_o, rd_valid_o, rd_data_o,
    output mem_addr_o, mem_wdata_o, mem_wr_rd_o, mem_valid_o, busy_o, done_o
  );

  modport master (
    output req_valid_i, req_wr_i, req_addr_i, req_len_i,
    output wd_valid_i, wd_data_i, rd_ready_i, mem_rdata_i, mem_ready_i,
    input  req_ready_o, wd_ready_o, rd_valid_o, rd_data_o,
    input  mem_addr_o, mem_wdata_o, mem_wr_rd_o, mem_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller: turns one (dir, addr, len) request into len single-word memory
// accesses, fed from / draining to valid-ready streams, with wrapping addresses.
module mem_burst_ctrl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic            clk_i,
  input logic            rst_ni,
  mem_burst_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WFETCH, S_ISSUE, S_RDOUT, S_DONE
  } state_e;

  state_e                state_q, state_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  req_ready_q, req_ready_d;
  logic                  wd_ready_q, wd_ready_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  mem_valid_q, mem_valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  // Next state, datapath updates and next values of the state-decoded outputs
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          wr_d   = bus.req_wr_i;
          addr_d = bus.req_addr_i;
          rem_d  = bus.req_len_i;
          if (bus.req_len_i == LEN_WIDTH'(0)) state_d = S_DONE;
          else if (bus.req_wr_i)              state_d = S_WFETCH;
          else                                state_d = S_ISSUE;
        end
      end
      S_WFETCH: begin
        if (bus.wd_valid_i) begin
          wdata_d = bus.wd_data_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (bus.mem_ready_i) begin
          rem_d  = rem_q - LEN_WIDTH'(1);
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (!wr_q) begin
            rdata_d = bus.mem_rdata_i;
            state_d = S_RDOUT;
          end else if (rem_q == LEN_WIDTH'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WFETCH;
          end
        end
      end
      S_RDOUT: begin
        // rem_q was already decremented when this word left memory
        if (bus.rd_ready_i) state_d = (rem_q != LEN_WIDTH'(0)) ? S_ISSUE : S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    wd_ready_d  = (state_d == S_WFETCH);
    mem_valid_d = (state_d == S_ISSUE);
    rd_valid_d  = (state_d == S_RDOUT);
    done_d      = (state_d == S_DONE);
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      rem_q       <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      wd_ready_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      wd_ready_q  <= wd_ready_d;
      mem_valid_q <= mem_valid_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
    end
  end

  assign bus.req_ready_o = req_ready_q;
  assign bus.busy_o      = busy_q;
  assign bus.wd_ready_o  = wd_ready_q;
  assign bus.mem_valid_o = mem_valid_q;
  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wr_rd_o = wr_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_data_o   = rdata_q;
  assign bus.done_o      = done_q;

endmodule

// File: doc/mem_burst_ctrl.md
MEM_BURST_CTRL -- requirements
Module: mem_burst_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 8, data width; ADDR_WIDTH, default 3, memory address width; LEN_WIDTH, default ADDR_WIDTH+1, burst length width.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk_i.
REQ-003 Ports SHALL be (name  direction  width  meaning):
  clk_i  in  1  clock
  rst_ni  in  1  async active-low reset
  req_valid_i  in  1  burst request valid
  req_ready_o  out  1  request accepted when high with req_valid_i
  req_wr_i  in  1  1 = write burst, 0 = read burst
  req_addr_i  in  ADDR_WIDTH  start address
  req_len_i  in  LEN_WIDTH  number of words
  wd_valid_i  in  1  write-data stream valid
  wd_ready_o  out  1  write-data stream ready
  wd_data_i  in  WIDTH  write-data word
  rd_valid_o  out  1  read-data stream valid
  rd_ready_i  in  1  read-data stream ready
  rd_data_o  out  WIDTH  read-data word
  mem_addr_o  out  ADDR_WIDTH  memory address
  mem_wdata_o  out  WIDTH  memory write data
  mem_rdata_i  in  WIDTH  memory read data
  mem_wr_rd_o  out  1  memory write enable (1 = write)
  mem_valid_o  out  1  memory request valid
  mem_ready_i  in  1  memory ready
  busy_o  out  1  high in any state except IDLE
  done_o  out  1  one-cycle pulse at burst end

Function
REQ-004 FSM states SHALL be IDLE, WFETCH, ISSUE, RDOUT and DONE.
REQ-005 req_ready_o SHALL be high only in IDLE; a request SHALL be accepted on any cycle where req_valid_i and req_ready_o are both high.
REQ-006 On accept, the block SHALL latch req_wr_i, req_addr_i into the address counter and req_len_i into the remaining counter; next state SHALL be DONE if req_len_i=0, else WFETCH (write) or ISSUE (read).
REQ-007 WFETCH SHALL drive wd_ready_o=1 and mem_valid_o=0; on wd_valid_i=1 it SHALL latch wd_data_i into mem_wdata_o and go to ISSUE.
REQ-008 ISSUE SHALL hold mem_valid_o=1, mem_addr_o=address counter and mem_wr_rd_o=latched direction until mem_ready_i=1 is sampled.
REQ-009 On mem_ready_i=1 in ISSUE, the block SHALL decrement the remaining count, increment the address modulo 2^ADDR_WIDTH, and drop mem_valid_o on the next cycle.
REQ-010 For reads, on mem_ready_i=1 in ISSUE, the block SHALL capture mem_rdata_i into rd_data_o and go to RDOUT.
REQ-011 For writes, on mem_ready_i=1 in ISSUE, the next state SHALL be WFETCH if remaining>0 after the decrement, else DONE.
REQ-012 RDOUT SHALL hold rd_valid_o=1 and rd_data_o stable until rd_ready_i=1; it SHALL then go to ISSUE if remaining>0, else DONE.
REQ-013 mem_valid_o SHALL be low for at least one cycle between successive memory transactions; mem_ready_i SHALL be ignored outside ISSUE.
REQ-014 With a slave that raises ready one cycle after valid and with streams always ready, each word SHALL take exactly 3 cycles.
REQ-015 DONE SHALL last one cycle with done_o=1 and SHALL then return to IDLE.
REQ-016 Address wrap: a burst from address 7 of length 3 (ADDR_WIDTH=3) SHALL access 7, 0, 1.
REQ-017 req_len_i values above 2^ADDR_WIDTH SHALL be honoured as given, with addresses wrapping.
REQ-018 Changes on req_* inputs outside IDLE SHALL have no effect.
REQ-019 A stalled wd_valid_i or rd_ready_i SHALL stall the FSM indefinitely with no memory access and no output change.

Reset
REQ-020 While rst_ni=0 the state SHALL be IDLE and mem_valid_o, mem_wr_rd_o, mem_addr_o, mem_wdata_o, rd_valid_o, rd_data_o, wd_ready_o, busy_o and done_o SHALL all be 0, with req_ready_o=1.
REQ-021 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously), with no done_o pulse and the remaining count discarded.

Verification
REQ-022 Write burst addr=2, len=3, data A1,B2,C3 always valid -> memory writes 2:A1, 3:B2, 4:C3; done_o pulses once, 9 cycles after accept plus DONE.
REQ-023 Read burst addr=6, len=4 after preload 6:11,7:22,0:33,1:44 -> rd_data_o sequence 11,22,33,44 with mem_addr_o wrapping 6,7,0,1.
REQ-024 Read burst with rd_ready_i held low 5 cycles on the second word -> rd_valid_o=1 and rd_data_o stable for 5 cycles, mem_valid_o=0 throughout, no data lost.
REQ-025 len=0 request -> no mem_valid_o assertion; done_o pulses on the cycle after accept.
REQ-026 rst_ni pulled low during ISSUE of word 2 of 4 -> mem_valid_o=0 immediately, no done_o, req_ready_o=1; a subsequent new burst runs correctly.
REQ-027 Slave delaying mem_ready_i 4 cycles -> mem_valid_o held 5 cycles with stable addr/wdata; exactly one word completes.
